// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx byte port among N_REQ requesters.
// A grant is held for a whole packet, bounded by MAX_BURST bytes and a STALL_CYC idle timeout.
module uart_tx_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16,
  parameter int STALL_CYC = 1024
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [N_REQ-1:0]          i_req_valid,
  input  logic [N_REQ*DATA_W-1:0]   i_req_data,
  input  logic [N_REQ-1:0]          i_req_last,
  output logic [N_REQ-1:0]          o_req_ready,
  output logic                      o_tx_valid,
  output logic [DATA_W-1:0]         o_tx_data,
  input  logic                      i_tx_ready,
  output logic                      o_grant_vld,
  output logic [$clog2(N_REQ)-1:0]  o_grant_id,
  output logic                      o_forced_rel
);

  localparam int IDW = $clog2(N_REQ);
  localparam int BCW = $clog2(MAX_BURST + 1);
  localparam int SCW = (STALL_CYC > 1) ? $clog2(STALL_CYC) : 1;

  typedef enum logic {IDLE, LOCK} state_t;

  state_t          r_state;
  logic [IDW-1:0]  r_rr_ptr;
  logic [IDW-1:0]  r_grant_id;
  logic            r_grant_vld;
  logic            r_forced_rel;
  logic [BCW-1:0]  r_byte_cnt;
  logic [SCW-1:0]  r_stall_cnt;

  logic            w_lock, w_gvalid, w_glast, w_xfer;
  logic            w_norm_end, w_burst_end, w_stall_end;
  logic            w_hit_hi, w_hit_lo;
  logic [IDW-1:0]  w_pick_hi, w_pick_lo, w_pick, w_next_ptr;

  // Outputs are gated by reset so a packet cut by reset loses its in-flight byte cleanly.
  assign w_lock      = (r_state == LOCK) && !i_rst;
  assign w_gvalid    = i_req_valid[r_grant_id];
  assign w_glast     = i_req_last[r_grant_id];
  assign o_tx_valid  = w_lock && w_gvalid;
  assign o_tx_data   = i_req_data[r_grant_id*DATA_W +: DATA_W];
  assign w_xfer      = o_tx_valid && i_tx_ready;
  assign w_norm_end  = w_xfer && w_glast;
  assign w_burst_end = w_xfer && (r_byte_cnt == BCW'(MAX_BURST - 1));
  assign w_stall_end = w_lock && !w_gvalid && (r_stall_cnt == SCW'(STALL_CYC - 1));
  assign w_next_ptr  = (r_grant_id == IDW'(N_REQ - 1)) ? '0 : r_grant_id + IDW'(1);

  assign o_grant_vld  = r_grant_vld;
  assign o_grant_id   = r_grant_id;
  assign o_forced_rel = r_forced_rel;

  always_comb begin
    o_req_ready = '0;
    for (int i = 0; i < N_REQ; i++)
      o_req_ready[i] = w_lock && i_tx_ready && (r_grant_id == IDW'(i));
  end

  // Lowest valid index at/after rr_ptr, else lowest valid overall (the wrap case).
  always_comb begin
    w_pick_hi = '0;
    w_pick_lo = '0;
    w_hit_hi  = 1'b0;
    w_hit_lo  = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (i_req_valid[i]) begin
        w_pick_lo = IDW'(i);
        w_hit_lo  = 1'b1;
        if (IDW'(i) >= r_rr_ptr) begin
          w_pick_hi = IDW'(i);
          w_hit_hi  = 1'b1;
        end
      end
    end
  end
  assign w_pick = w_hit_hi ? w_pick_hi : w_pick_lo;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_rr_ptr     <= '0;
      r_grant_id   <= '0;
      r_grant_vld  <= 1'b0;
      r_forced_rel <= 1'b0;
      r_byte_cnt   <= '0;
      r_stall_cnt  <= '0;
    end else begin
      r_forced_rel <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_hit_lo) begin
            r_state     <= LOCK;
            r_grant_id  <= w_pick;
            r_grant_vld <= 1'b1;
            r_byte_cnt  <= '0;
            r_stall_cnt <= '0;
          end
        end
        LOCK: begin
          if (w_xfer)
            r_byte_cnt <= r_byte_cnt + BCW'(1);
          // Backpressure with valid high is not a stall.
          if (w_gvalid)
            r_stall_cnt <= '0;
          else if (r_stall_cnt != SCW'(STALL_CYC - 1))
            r_stall_cnt <= r_stall_cnt + SCW'(1);
          if (w_norm_end || w_burst_end || w_stall_end) begin
            r_state      <= IDLE;
            r_grant_vld  <= 1'b0;
            r_rr_ptr     <= w_next_ptr;
            r_forced_rel <= !w_norm_end;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
